// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned DEFAULT_DATA_BITS    = 8;

  // Parity-mode selectors for the PARITY_ODD parameter
  localparam bit PAR_MODE_EVEN = 1'b0;
  localparam bit PAR_MODE_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Unused upper bits must be zero so they do not disturb the XOR
  function automatic logic parity_bit(input logic [7:0] data, input bit odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_controller_if.sv
// Host-side byte handshake plus serial line and status for the UART transmitter.
interface uart_tx_controller_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 busy;
  logic                 done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx,
    output busy,
    output done
  );

endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the final count.
// A synchronous clear restarts the period so bit edges align to frame start.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("baud_tick_gen: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_tick;

  // Wrap on the last count; clear wins over counting
  always_comb begin
    w_count_next = r_count + CNT_W'(1);
    if (clear || (r_count == LAST_CNT)) begin
      w_count_next = '0;
    end
  end

  // Tick is registered and high exactly while the count sits at its last value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_tick  <= (w_count_next == LAST_CNT);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: accepts a byte on valid/ready and serialises
// start, data (LSB first), optional parity and stop bits onto tx.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = PAR_MODE_EVEN,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  uart_tx_controller_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  generate
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_data_bits
      $error("uart_tx_controller: DATA_BITS must be 5..8");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $error("uart_tx_controller: STOP_BITS must be 1 or 2");
    end
  endgenerate

  state_e               r_state;
  state_e               w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_next;
  logic                 r_stop;
  logic                 w_stop_next;
  logic                 r_parity;
  logic                 w_parity_next;
  logic                 r_tx;
  logic                 w_tx_next;
  logic                 r_busy;
  logic                 w_busy_next;
  logic                 r_ready;
  logic                 w_ready_next;
  logic                 r_done;
  logic                 w_done_next;

  logic [DATA_BITS-1:0] w_data;
  logic                 w_valid;
  logic                 w_tick;
  logic                 w_clear;

  assign w_data  = bus.tx_data;
  assign w_valid = bus.tx_valid;

  // Counter is parked at zero in IDLE, so the first bit period starts at acceptance
  assign w_clear = (r_state == IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clock (clock),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Next-state and next-output logic; tx is computed for the state being entered
  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_idx_next    = r_idx;
    w_stop_next   = r_stop;
    w_parity_next = r_parity;
    w_tx_next     = r_tx;
    w_busy_next   = r_busy;
    w_ready_next  = r_ready;
    w_done_next   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_next  = START;
          w_shift_next  = w_data;
          w_parity_next = parity_bit(8'(w_data), (PARITY_ODD == PAR_MODE_ODD));
          w_idx_next    = '0;
          w_stop_next   = 1'b0;
          w_tx_next     = 1'b0;
          w_busy_next   = 1'b1;
          w_ready_next  = 1'b0;
        end
      end

      START: begin
        if (w_tick) begin
          w_state_next = DATA;
          w_tx_next    = r_shift[0];
        end
      end

      DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_idx == LAST_IDX) begin
            if (PARITY_EN) begin
              w_state_next = PARITY;
              w_tx_next    = r_parity;
            end else begin
              w_state_next = STOP;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
            w_tx_next  = r_shift[1];
          end
        end
      end

      PARITY: begin
        if (w_tick) begin
          w_state_next = STOP;
          w_tx_next    = 1'b1;
        end
      end

      STOP: begin
        if (w_tick) begin
          if (r_stop == LAST_STOP) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
            w_ready_next = 1'b1;
            w_busy_next  = 1'b0;
            w_tx_next    = 1'b1;
          end else begin
            w_stop_next = r_stop + 1'b1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_idx    <= '0;
      r_stop   <= 1'b0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_idx    <= w_idx_next;
      r_stop   <= w_stop_next;
      r_parity <= w_parity_next;
      r_tx     <= w_tx_next;
      r_busy   <= w_busy_next;
      r_ready  <= w_ready_next;
      r_done   <= w_done_next;
    end
  end

  assign bus.tx       = r_tx;
  assign bus.busy     = r_busy;
  assign bus.tx_ready = r_ready;
  assign bus.done     = r_done;

endmodule
